// File: rtl/dau_addsub_sequencer.sv
// Micro-sequencer for signed fixed-point decimal add/subtract: aligns commas with
// SHL, optionally compares magnitudes, then issues ADD or SUB to the BCDU.
module dau_addsub_sequencer #(
    parameter int COMMA_POS_W = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_sub,
    input  logic                   i_sign_a,
    input  logic                   i_sign_b,
    input  logic [COMMA_POS_W-1:0] i_comma_pos_a,
    input  logic [COMMA_POS_W-1:0] i_comma_pos_b,
    input  logic [3:0]             i_digits_addr_a,
    input  logic [3:0]             i_digits_addr_b,
    input  logic                   i_gt_flag,
    input  logic                   i_eq_flag,
    input  logic                   i_instr_accept,
    output logic                   o_instr_valid,
    output logic [15:0]            o_instr,
    output logic                   o_sign,
    output logic [COMMA_POS_W-1:0] o_comma_pos,
    output logic                   o_ready,
    output logic [2:0]             o_dbg_state
);

    // Instruction handshake: o_instr is stable while o_instr_valid is high; a cycle
    // with valid && accept is the single transfer, and valid is low the next cycle.
    // A later cycle with accept high means the BCDU has finished that instruction.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALIGN    = 3'd1,
        S_SHL      = 3'd2,
        S_SHL_WAIT = 3'd3,
        S_CMP      = 3'd4,
        S_CMP_WAIT = 3'd5,
        S_OP       = 3'd6,
        S_FIN      = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;

    state_t                 r_state;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic [COMMA_POS_W-1:0] r_comma_a;
    logic [COMMA_POS_W-1:0] r_comma_b;
    logic [3:0]             r_addr_a;
    logic [3:0]             r_addr_b;
    logic                   r_res_sign;

    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_comma_a     <= '0;
            r_comma_b     <= '0;
            r_addr_a      <= 4'd0;
            r_addr_b      <= 4'd0;
            r_res_sign    <= 1'b0;
            o_instr_valid <= 1'b0;
            o_instr       <= 16'd0;
            o_sign        <= 1'b0;
            o_comma_pos   <= '0;
            o_ready       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && o_ready) begin
                        // Subtraction is folded into B's effective sign.
                        r_sign_a  <= i_sign_a;
                        r_sign_b  <= i_sign_b ^ i_sub;
                        r_comma_a <= i_comma_pos_a;
                        r_comma_b <= i_comma_pos_b;
                        r_addr_a  <= i_digits_addr_a;
                        r_addr_b  <= i_digits_addr_b;
                        o_ready   <= 1'b0;
                        r_state   <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    o_instr_valid <= 1'b1;
                    if (r_comma_a < r_comma_b) begin
                        o_instr <= {OP_SHL, r_addr_a, r_addr_a, 4'd0};
                        r_state <= S_SHL;
                    end else if (r_comma_b < r_comma_a) begin
                        o_instr <= {OP_SHL, r_addr_b, r_addr_b, 4'd0};
                        r_state <= S_SHL;
                    end else if (r_sign_a == r_sign_b) begin
                        o_instr    <= {OP_ADD, r_addr_a, r_addr_a, r_addr_b};
                        r_res_sign <= r_sign_a;
                        r_state    <= S_OP;
                    end else begin
                        o_instr <= {OP_CMP, 4'd0, r_addr_a, r_addr_b};
                        r_state <= S_CMP;
                    end
                end
                S_SHL: begin
                    if (i_instr_accept) begin
                        o_instr_valid <= 1'b0;
                        if (r_comma_a < r_comma_b) r_comma_a <= r_comma_a + 1'b1;
                        else                       r_comma_b <= r_comma_b + 1'b1;
                        r_state <= S_SHL_WAIT;
                    end
                end
                S_SHL_WAIT: begin
                    if (i_instr_accept) r_state <= S_ALIGN;
                end
                S_CMP: begin
                    if (i_instr_accept) begin
                        o_instr_valid <= 1'b0;
                        r_state       <= S_CMP_WAIT;
                    end
                end
                S_CMP_WAIT: begin
                    // Flags are only meaningful once the CMP has completed.
                    if (i_instr_accept) begin
                        o_instr_valid <= 1'b1;
                        r_state       <= S_OP;
                        if (i_gt_flag) begin
                            o_instr    <= {OP_SUB, r_addr_a, r_addr_a, r_addr_b};
                            r_res_sign <= r_sign_a;
                        end else if (i_eq_flag) begin
                            o_instr    <= {OP_SUB, r_addr_a, r_addr_a, r_addr_b};
                            r_res_sign <= 1'b0;
                        end else begin
                            o_instr    <= {OP_SUB, r_addr_a, r_addr_b, r_addr_a};
                            r_res_sign <= r_sign_b;
                        end
                    end
                end
                S_OP: begin
                    if (i_instr_accept) begin
                        o_instr_valid <= 1'b0;
                        r_state       <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (i_instr_accept) begin
                        o_sign      <= r_res_sign;
                        o_comma_pos <= r_comma_a;
                        o_ready     <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dau_addsub_sequencer.sv
// Directed bench for dau_addsub_sequencer: the bench acts as the BCDU and checks
// the instruction stream and result descriptor against an expected queue.
module tb_dau_addsub_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_sub, i_sign_a, i_sign_b;
    logic [1:0]  i_comma_pos_a, i_comma_pos_b;
    logic [3:0]  i_digits_addr_a, i_digits_addr_b;
    logic        i_gt_flag, i_eq_flag, i_instr_accept;
    logic        o_instr_valid;
    logic [15:0] o_instr;
    logic        o_sign;
    logic [1:0]  o_comma_pos;
    logic        o_ready;
    logic [2:0]  o_dbg_state;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_xfer = 0;
    int          x0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    dau_addsub_sequencer #(.COMMA_POS_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_sub(i_sub),
        .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
        .i_comma_pos_a(i_comma_pos_a), .i_comma_pos_b(i_comma_pos_b),
        .i_digits_addr_a(i_digits_addr_a), .i_digits_addr_b(i_digits_addr_b),
        .i_gt_flag(i_gt_flag), .i_eq_flag(i_eq_flag), .i_instr_accept(i_instr_accept),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_sign(o_sign),
        .o_comma_pos(o_comma_pos), .o_ready(o_ready), .o_dbg_state(o_dbg_state)
    );

    always @(posedge clk) begin
        if (o_instr_valid && i_instr_accept) n_xfer <= n_xfer + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; leaves the sequencer busy one cycle later.
    task automatic start_op(input logic sub, input logic sa, input logic [1:0] ca,
                            input logic [3:0] aa, input logic sb, input logic [1:0] cb,
                            input logic [3:0] ab);
        i_sub = sub; i_sign_a = sa; i_comma_pos_a = ca; i_digits_addr_a = aa;
        i_sign_b = sb; i_comma_pos_b = cb; i_digits_addr_b = ab;
        x0 = n_xfer;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start latency", {15'd0, o_ready}, 16'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !o_instr_valid; i++) @(negedge clk);
        chk({tag, " valid seen"}, {15'd0, o_instr_valid}, 16'd1);
    endtask

    task automatic finish_op(input string tag, input logic es, input logic [1:0] ec,
                             input int nx);
        for (int i = 0; i < 80 && !o_ready; i++) begin
            if (o_instr_valid && i_instr_accept) begin
                if (exp_q.size() == 0) chk({tag, " unexpected instr"}, o_instr, 16'hffff);
                else                   chk({tag, " instr"}, o_instr, exp_q.pop_front());
            end
            @(negedge clk);
        end
        chk({tag, " ready"}, {15'd0, o_ready}, 16'd1);
        chk({tag, " queue left"}, 16'(exp_q.size()), 16'd0);
        chk({tag, " sign"}, {15'd0, o_sign}, {15'd0, es});
        chk({tag, " comma"}, {14'd0, o_comma_pos}, {14'd0, ec});
        chk({tag, " transfers"}, 16'(n_xfer - x0), 16'(nx));
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_sub = 1'b0; i_sign_a = 1'b0; i_sign_b = 1'b0;
        i_comma_pos_a = 2'd0; i_comma_pos_b = 2'd0; i_digits_addr_a = 4'd0;
        i_digits_addr_b = 4'd0; i_gt_flag = 1'b0; i_eq_flag = 1'b0; i_instr_accept = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset ready", {15'd0, o_ready}, 16'd1);
        chk("reset valid", {15'd0, o_instr_valid}, 16'd0);
        chk("reset instr", o_instr, 16'd0);
        chk("reset sign/comma", {13'd0, o_sign, o_comma_pos}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // +12.5 + +3: one SHL on B, then ADD
        exp_q.push_back(16'h4330); exp_q.push_back(16'h1223);
        start_op(1'b0, 1'b0, 2'd1, 4'd2, 1'b0, 2'd0, 4'd3);
        finish_op("add_align", 1'b0, 2'd1, 2);

        // +5 - +7: |A|<|B| so B-A, negative
        i_gt_flag = 1'b0; i_eq_flag = 1'b0;
        exp_q.push_back(16'h3023); exp_q.push_back(16'h2232);
        start_op(1'b1, 1'b0, 2'd0, 4'd2, 1'b0, 2'd0, 4'd3);
        finish_op("sub_lt", 1'b1, 2'd0, 2);

        // -4 + +4: equal magnitudes give positive zero
        i_gt_flag = 1'b0; i_eq_flag = 1'b1;
        exp_q.push_back(16'h3023); exp_q.push_back(16'h2223);
        start_op(1'b0, 1'b1, 2'd0, 4'd2, 1'b0, 2'd0, 4'd3);
        finish_op("add_eq", 1'b0, 2'd0, 2);

        // +3 - (-1.25): two SHLs on A, then ADD, comma 2
        exp_q.push_back(16'h4220); exp_q.push_back(16'h4220); exp_q.push_back(16'h1223);
        start_op(1'b1, 1'b0, 2'd0, 4'd2, 1'b1, 2'd2, 4'd3);
        finish_op("sub_align2", 1'b0, 2'd2, 3);

        // -9 + +2: |A|>|B|, sign of A
        i_gt_flag = 1'b1; i_eq_flag = 1'b0;
        exp_q.push_back(16'h3059); exp_q.push_back(16'h2559);
        start_op(1'b0, 1'b1, 2'd0, 4'd5, 1'b0, 2'd0, 4'd9);
        finish_op("add_gt", 1'b1, 2'd0, 2);

        // +0.002 + -0.009 at max comma: B-A into A, sign of B
        i_gt_flag = 1'b0; i_eq_flag = 1'b0;
        exp_q.push_back(16'h3059); exp_q.push_back(16'h2595);
        start_op(1'b0, 1'b0, 2'd3, 4'd5, 1'b1, 2'd3, 4'd9);
        finish_op("add_lt_c3", 1'b1, 2'd3, 2);

        // Reset while waiting for CMP completion
        start_op(1'b1, 1'b0, 2'd0, 4'd2, 1'b0, 2'd0, 4'd3);
        wait_valid("rst_cmp");
        chk("rst_cmp instr", o_instr, 16'h3023);
        @(negedge clk);
        i_instr_accept = 1'b0;
        @(negedge clk);
        chk("rst_cmp waiting", {13'd0, o_ready, o_instr_valid, 1'b0}, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst ready/valid", {14'd0, o_ready, o_instr_valid}, 16'd2);
        chk("midrst instr", o_instr, 16'd0);
        chk("midrst sign/comma", {13'd0, o_sign, o_comma_pos}, 16'd0);
        chk("midrst state", {13'd0, o_dbg_state}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1; i_instr_accept = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h3023); exp_q.push_back(16'h2232);
        start_op(1'b1, 1'b0, 2'd0, 4'd2, 1'b0, 2'd0, 4'd3);
        finish_op("after_rst", 1'b1, 2'd0, 2);

        // Stalled ADD: instruction stays put, a busy start is ignored
        i_instr_accept = 1'b0;
        exp_q.push_back(16'h1223);
        start_op(1'b0, 1'b0, 2'd0, 4'd2, 1'b0, 2'd0, 4'd3);
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall valid", {15'd0, o_instr_valid}, 16'd1);
            chk("stall instr", o_instr, 16'h1223);
            i_start = (i == 1);
            i_sign_a = (i == 1); i_sub = (i == 1); i_comma_pos_b = (i == 1) ? 2'd2 : 2'd0;
            @(negedge clk);
        end
        i_start = 1'b0; i_instr_accept = 1'b1;
        finish_op("stall", 1'b0, 2'd0, 1);
        chk("idle after stall", {13'd0, o_dbg_state}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
